// File: rtl/recovery_regfile_ckpt.sv
// recovery_regfile_ckpt: register file with a dirty-tracked checkpoint bank for rollback after a voter mismatch
module recovery_regfile_ckpt #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 32,
   parameter int NRD     = 2,
   parameter bit ZERO_R0 = 1'b1,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     wa,
   input  logic [DATA_W-1:0]     wd,
   input  logic [NRD*ADDR_W-1:0] ra,
   output logic [NRD*DATA_W-1:0] rd,
   input  logic                  ckpt_req,
   input  logic                  rstr_req,
   output logic                  busy,
   output logic                  done,
   output logic                  wr_drop,
   output logic                  dirty_any
);
   typedef enum logic [1:0] {IDLE, COMMIT, RESTORE, DONE} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   state_t            state, state_nx;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] live [DEPTH];
   logic [DATA_W-1:0] ckpt [DEPTH];
   logic [DEPTH-1:0]  dirty;
   logic              wa_ok, wr_ok, walking;
   assign wa_ok   = 32'(wa) < DEPTH;
   assign wr_ok   = we && state == IDLE && wa_ok && !(ZERO_R0 && wa == '0);
   assign walking = state == COMMIT || state == RESTORE;
   // state register
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_nx;
   end
   // next state: restore wins over commit, walks end after the last entry
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:            state_nx = rstr_req ? RESTORE : (ckpt_req ? COMMIT : IDLE);
         COMMIT, RESTORE: state_nx = (idx == LAST) ? DONE : state;
         default:         state_nx = IDLE;
      endcase
   end
   // status outputs decoded from state and dirty bits
   always_comb begin
      busy      = state != IDLE;
      done      = state == DONE;
      dirty_any = |dirty;
   end
   // banks, dirty bits, walk index and dropped-write flag
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            live[i] <= '0;
            ckpt[i] <= '0;
         end
         dirty   <= '0;
         idx     <= '0;
         wr_drop <= 1'b0;
      end else begin
         wr_drop <= we && (state != IDLE || !wa_ok);
         if (wr_ok) begin
            live[wa]  <= wd;
            dirty[wa] <= 1'b1;
         end
         if (state == COMMIT) begin
            if (dirty[idx]) ckpt[idx] <= live[idx];
            dirty[idx] <= 1'b0;
         end
         if (state == RESTORE) begin
            if (dirty[idx]) live[idx] <= ckpt[idx];
            dirty[idx] <= 1'b0;
         end
         idx <= (walking && idx != LAST) ? idx + ADDR_W'(1) : '0;
      end
   end
   // combinational read ports; out-of-range, hard-zero entry and reset all read as 0
   always_comb begin
      rd = '0;
      for (int p = 0; p < NRD; p++)
         if (rst_in && 32'(ra[p*ADDR_W +: ADDR_W]) < DEPTH && !(ZERO_R0 && ra[p*ADDR_W +: ADDR_W] == '0))
            rd[p*DATA_W +: DATA_W] = live[ra[p*ADDR_W +: ADDR_W]];
   end
endmodule

// File: doc/recovery_regfile_ckpt.md
Name: recovery_regfile_ckpt

Overview:
- Parametrised architectural register file for the TMR RISC-V core. It adds a shadow checkpoint bank so the recovery controller can roll state back after a voter mismatch.
- It holds a live bank L, a checkpoint bank C and one dirty bit per entry.
- Commit walks L->C and restore walks C->L, one entry per cycle. Only dirty entries are copied.
- There are NRD combinational read ports and one write port. It replaces the fixed 32x32 single-port recovery register.

Parameters:
- DATA_W, 32: word width.
- DEPTH, 32: number of entries, >=2. Localparam ADDR_W = $clog2(DEPTH).
- NRD, 2: number of read ports.
- ZERO_R0, 1: when 1, entry 0 is hard-wired to 0, writes to it are silently discarded and its dirty bit is never set.

Ports:
- clk  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- ra  in  NRD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rd  out  NRD*DATA_W  read data, port p at [p*DATA_W +: DATA_W].
- ckpt_req  in  1  request commit L->C.
- rstr_req  in  1  request restore C->L.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of a walk.
- wr_drop  out  1  one-cycle pulse, registered, when a write was discarded.
- dirty_any  out  1  OR of all dirty bits.

Behaviour:
- Reset (rst_in=0, async):
  - All L, C entries = 0; all dirty bits = 0; state = IDLE; idx = 0.
  - busy = done = wr_drop = dirty_any = 0.
  - rd is forced to 0 while rst_in = 0.
- Reads:
  - Combinational: rd[p] = L[ra[p]].
  - ra >= DEPTH returns 0.
  - Entry 0 returns 0 when ZERO_R0 = 1.
  - No write-through: a write in cycle T is visible on rd from cycle T+1.
- Writes:
  - Accepted at the clock edge when we=1, state=IDLE and wa<DEPTH: L[wa]<=wd, dirty[wa]<=1.
  - Discarded when we=1 and state!=IDLE, or when wa>=DEPTH; wr_drop=1 in the following cycle.
  - A ZERO_R0 write to entry 0 is discarded without asserting wr_drop.
- States: IDLE, COMMIT, RESTORE, DONE.
- IDLE:
  - rstr_req=1 -> RESTORE, idx<=0.
  - Otherwise ckpt_req=1 -> COMMIT, idx<=0.
  - Restore has priority over commit.
  - A write in the same IDLE cycle is performed and its dirty bit is included in the walk.
- COMMIT: each edge processes idx. If dirty[idx], C[idx]<=L[idx]. dirty[idx]<=0 in all cases. idx<=idx+1.
- RESTORE: each edge processes idx. If dirty[idx], L[idx]<=C[idx]. dirty[idx]<=0 in all cases. idx<=idx+1.
- End of walk: at the edge processing idx=DEPTH-1 -> DONE, idx<=0.
- DONE: lasts one cycle with done=1, then -> IDLE.
- Requests are ignored when state != IDLE; they are not queued.
- Latency: request sampled at edge E0; busy is high for DEPTH+1 cycles (DEPTH walk cycles plus DONE). done is high in cycle DEPTH+1 after E0. A back-to-back request is accepted at the edge leaving DONE only if it is presented in IDLE, i.e. the earliest is the cycle after done.
- Walk-cycle counts:
  - The walk always takes DEPTH cycles, regardless of how many entries are dirty.
  - Commit with no dirty entries still takes DEPTH cycles and leaves C unchanged.
- After either walk all dirty bits = 0, so dirty_any=0 in the DONE cycle.
- During RESTORE, reads return L as it is being rewritten: entries below idx are already restored, entries at or above idx are not.
- Reset asserted mid-walk: everything returns to reset values immediately; the partial copy is lost.

Test Plan:
- Reset then read: pulse rst_in low, read ra0=1, ra1=31 -> rd0=0, rd1=0; busy=0; dirty_any=0.
- Write/read timing: write L[3]=0x0000000F at edge T -> rd0 with ra0=3 shows 0xF from T+1, dirty_any=1. Write to wa=0 -> rd=0 and no wr_drop.
- Commit then restore: write L[1]=3, L[2]=9; ckpt_req -> busy for 33 cycles, done pulse at cycle 33 after request. Then write L[1]=0xAA, L[5]=7 and rstr_req -> after done: L[1]=3, L[5]=0 (C[5]=0), L[2]=9, dirty_any=0.
- Write during walk: we=1, wa=4, wd=0x55 while busy=1 -> wr_drop=1 for one cycle, L[4] unchanged. ckpt_req raised mid-walk -> ignored, only one done pulse.
- Simultaneous requests: ckpt_req=rstr_req=1 in IDLE with L[2]=0x11, C[2]=9 dirty -> restore executes, L[2]=9, C[2]=9.
- Reset mid-walk plus parameter sweep: rst_in low at walk cycle 10 -> busy=0, L and C all 0. Repeat the commit/restore scenario with DEPTH=16, DATA_W=64, NRD=3: busy lasts 17 cycles and all three read ports give correct data.
